dedicated_proc_param: RTL and testbench

Parametrised dedicated processor: FSM controller plus register-file datapath, single adder, immediate mux and buffered output port.

---
 rtl/dp_pkg.sv | 12 +
 rtl/dp_regfile.sv | 32 +++
 rtl/dedicated_proc_param.sv | 105 ++++++++++
 tb/tb_dedicated_proc_param.sv | 118 +++++++++++
 4 files changed

// File: rtl/dp_pkg.sv
// dp_pkg: shared states, modes, register indices and immediates for the dedicated processor
package dp_pkg;
    typedef enum logic [3:0] {IDLE, INIT_A, INIT_B, INIT_C, CMP, INC, ACC, ADD, MOV1, MOV2, OUT} state_t;
    typedef enum logic {MODE_SUM = 1'b0, MODE_FIB = 1'b1} mode_t;
    localparam int R0 = 0;
    localparam int R1 = 1;
    localparam int R2 = 2;
    localparam int R3 = 3;
    localparam int R4 = 4;
    localparam logic IMM0 = 1'b0;
    localparam logic IMM1 = 1'b1;
endpackage

// File: rtl/dp_regfile.sv
// dp_regfile: 2-read 1-write register file with R0 hardwired to zero
module dp_regfile
    import dp_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int REG_NUM = 8,
    parameter int AW      = $clog2(REG_NUM)
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              we,
    input  logic [AW-1:0]     waddr,
    input  logic [DATA_W-1:0] wdata,
    input  logic [AW-1:0]     raddr1,
    input  logic [AW-1:0]     raddr2,
    output logic [DATA_W-1:0] rdata1,
    output logic [DATA_W-1:0] rdata2
);
    logic [DATA_W-1:0] regs [REG_NUM];

    assign rdata1 = (raddr1 == AW'(R0)) ? '0 : regs[raddr1];
    assign rdata2 = (raddr2 == AW'(R0)) ? '0 : regs[raddr2];

    // single synchronous write port; writes aimed at R0 are dropped
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            for (int i = 0; i < REG_NUM; i++) regs[i] <= '0;
        end else if (we && waddr != AW'(R0)) begin
            regs[waddr] <= wdata;
        end
    end
endmodule

// File: rtl/dedicated_proc_param.sv
// dedicated_proc_param: FSM-driven processor computing sum 1..N or Fibonacci F(N)
module dedicated_proc_param
    import dp_pkg::*;
#(
    parameter int DATA_W  = 8,
    parameter int REG_NUM = 8
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              start,
    input  logic              mode,
    input  logic [DATA_W-1:0] limit,
    output logic              busy,
    output logic              done,
    output logic              ovf,
    output logic [DATA_W-1:0] outport
);
    localparam int AW = $clog2(REG_NUM);

    state_t            state;
    mode_t             mode_q;
    logic [DATA_W-1:0] limit_q;
    logic              ovf_q;
    logic [AW-1:0]     ra1, ra2, wa;
    logic              we, mux_sel, imm, cin;
    logic [DATA_W-1:0] rdata1, rdata2, wdata, sum;
    logic              carry, fib, lt;

    assign fib = (mode_q == MODE_FIB);
    // counter increments reuse the adder through its carry-in with R0 as the second operand
    assign {carry, sum} = {1'b0, rdata1} + {1'b0, rdata2} + (DATA_W + 1)'(cin);
    assign wdata = mux_sel ? DATA_W'(imm) : sum;
    assign lt = rdata1 < limit_q;

    dp_regfile #(.DATA_W(DATA_W), .REG_NUM(REG_NUM)) u_rf (
        .clk(clk), .rst(rst), .we(we), .waddr(wa), .wdata(wdata),
        .raddr1(ra1), .raddr2(ra2), .rdata1(rdata1), .rdata2(rdata2)
    );

    // per-state datapath control: register addresses, write enable and write-source select
    always_comb begin
        ra1 = AW'(R0);
        ra2 = AW'(R0);
        wa = AW'(R0);
        we = 1'b0;
        mux_sel = 1'b0;
        imm = IMM0;
        cin = 1'b0;
        case (state)
            INIT_A: begin we = 1'b1; wa = AW'(R1); mux_sel = 1'b1; end
            INIT_B: begin we = 1'b1; wa = AW'(R2); mux_sel = 1'b1; imm = fib ? IMM1 : IMM0; end
            INIT_C: begin we = 1'b1; wa = AW'(R3); mux_sel = 1'b1; end
            CMP:    ra1 = fib ? AW'(R3) : AW'(R1);
            INC:    begin ra1 = fib ? AW'(R3) : AW'(R1); wa = ra1; we = 1'b1; cin = 1'b1; end
            ACC:    begin ra1 = AW'(R2); ra2 = AW'(R1); wa = AW'(R2); we = 1'b1; end
            ADD:    begin ra1 = AW'(R1); ra2 = AW'(R2); wa = AW'(R4); we = 1'b1; end
            MOV1:   begin ra1 = AW'(R2); wa = AW'(R1); we = 1'b1; end
            MOV2:   begin ra1 = AW'(R4); wa = AW'(R2); we = 1'b1; end
            OUT:    ra1 = fib ? AW'(R1) : AW'(R2);
            default: ;
        endcase
    end

    // controller: sequencing, run latching, sticky overflow and registered handshake outputs
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state   <= IDLE;
            mode_q  <= MODE_SUM;
            limit_q <= '0;
            ovf_q   <= 1'b0;
            busy    <= 1'b0;
            done    <= 1'b0;
            ovf     <= 1'b0;
            outport <= '0;
        end else begin
            done <= 1'b0;
            case (state)
                IDLE: if (start) begin
                    state   <= INIT_A;
                    mode_q  <= mode_t'(mode);
                    limit_q <= limit;
                    ovf_q   <= 1'b0;
                    busy    <= 1'b1;
                end
                INIT_A: state <= INIT_B;
                INIT_B: state <= fib ? INIT_C : CMP;
                INIT_C: state <= CMP;
                CMP:    state <= lt ? (fib ? ADD : INC) : OUT;
                INC:    state <= fib ? CMP : ACC;
                ACC:    begin ovf_q <= ovf_q | carry; state <= CMP; end
                ADD:    begin ovf_q <= ovf_q | carry; state <= MOV1; end
                MOV1:   state <= MOV2;
                MOV2:   state <= INC;
                OUT: begin
                    outport <= rdata1;
                    ovf     <= ovf_q;
                    done    <= 1'b1;
                    busy    <= 1'b0;
                    state   <= IDLE;
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_dedicated_proc_param.sv
// tb_dedicated_proc_param: directed checks of both programs, overflow, N=0, mid-run disturbance and reset
module tb_dedicated_proc_param;
    logic       clk = 1'b0;
    logic       rst;
    logic       start;
    logic       mode;
    logic [7:0] limit;
    logic       busy, done, ovf;
    logic [7:0] outport;
    int checks = 0;
    int failures = 0;

    dedicated_proc_param #(.DATA_W(8), .REG_NUM(8)) dut (
        .clk(clk), .rst(rst), .start(start), .mode(mode), .limit(limit),
        .busy(busy), .done(done), .ovf(ovf), .outport(outport)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic run(input string tag, input logic m, input logic [7:0] n, input logic [7:0] eo,
                       input logic eovf, input int lat, input bit disturb);
        int first = 0;
        int dones = 0;
        int busy_cnt = 0;
        mode = m;
        limit = n;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        chk({tag, "_busy_start"}, busy, 1);
        for (int i = 1; i <= lat + 4; i++) begin
            if (disturb && i >= 3 && i <= 8) begin
                start = 1'b1;
                mode = ~m;
                limit = 8'd200;
            end else begin
                start = 1'b0;
            end
            @(posedge clk);
            #1;
            if (i < lat && busy) busy_cnt++;
            if (done) begin
                dones++;
                if (first == 0) begin
                    first = i;
                    chk({tag, "_out"}, outport, eo);
                    chk({tag, "_ovf"}, ovf, eovf);
                    chk({tag, "_busy_done"}, busy, 0);
                end
            end
        end
        chk({tag, "_latency"}, first, lat);
        chk({tag, "_dones"}, dones, 1);
        chk({tag, "_busy_cycles"}, busy_cnt, lat - 1);
        chk({tag, "_hold"}, outport, eo);
    endtask

    initial begin
        rst = 1'b0;
        start = 1'b0;
        mode = 1'b0;
        limit = 8'd0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_busy", busy, 0);
        chk("rst_done", done, 0);
        chk("rst_ovf", ovf, 0);
        chk("rst_out", outport, 0);
        rst = 1'b1;
        @(posedge clk);
        #1;
        run("sum10", 1'b0, 8'd10, 8'd55, 1'b0, 34, 1'b0);
        run("fib10", 1'b1, 8'd10, 8'd55, 1'b0, 55, 1'b0);
        run("fib12", 1'b1, 8'd12, 8'd144, 1'b0, 65, 1'b0);
        run("fib13", 1'b1, 8'd13, 8'd233, 1'b1, 70, 1'b0);
        run("sum23", 1'b0, 8'd23, 8'd20, 1'b1, 73, 1'b0);
        run("sum22", 1'b0, 8'd22, 8'd253, 1'b0, 70, 1'b0);
        run("sum0", 1'b0, 8'd0, 8'd0, 1'b0, 4, 1'b0);
        run("fib0", 1'b1, 8'd0, 8'd0, 1'b0, 5, 1'b0);
        run("sum5_dist", 1'b0, 8'd5, 8'd15, 1'b0, 19, 1'b1);
        repeat (5) @(posedge clk);
        #1;
        chk("sum5_hold_idle", outport, 15);
        run("fib13_b", 1'b1, 8'd13, 8'd233, 1'b1, 70, 1'b0);
        mode = 1'b1;
        limit = 8'd10;
        start = 1'b1;
        @(posedge clk);
        #1;
        start = 1'b0;
        repeat (20) @(posedge clk);
        #3;
        rst = 1'b0;
        #1;
        chk("midrst_busy", busy, 0);
        chk("midrst_done", done, 0);
        chk("midrst_ovf", ovf, 0);
        chk("midrst_out", outport, 0);
        repeat (2) @(posedge clk);
        #1;
        rst = 1'b1;
        @(posedge clk);
        #1;
        chk("postrst_busy", busy, 0);
        run("sum4", 1'b0, 8'd4, 8'd10, 1'b0, 16, 1'b0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
